// File: rtl/lcd_page_scheduler_if.sv
// Handshake bundle between the LCD page scheduler and its surroundings.
// The master side is the scheduler; the slave side is the content
// sources and the LCD writer.
interface lcd_page_scheduler_if;
  logic [3:0] src_req;
  logic       lcd_ready;
  logic       frame_done;
  logic       frame_start;
  logic [1:0] src_sel;
  logic       blank;
  logic       switch_pulse;
  logic       timeout_err;

  modport master (
    input  src_req, lcd_ready, frame_done,
    output frame_start, src_sel, blank, switch_pulse, timeout_err
  );

  modport slave (
    output src_req, lcd_ready, frame_done,
    input  frame_start, src_sel, blank, switch_pulse, timeout_err
  );
endinterface

// File: rtl/lcd_page_scheduler.sv
// lcd_page_scheduler: decides which content source owns the shared 2x16 LCD
// and drives the writer one frame at a time. Ownership only moves at frame
// boundaries. Critical sources preempt once the current owner has been shown
// for MIN_HOLD cycles. Non-critical sources rotate every PAGE_TIME cycles.
//
// state       | meaning
// S_WAIT_INIT | writer not ready; owner and hold time are preserved
// S_DECIDE    | one-cycle owner decision; src_sel/blank/switch_pulse registered
// S_ISSUE     | frame_start high for this single cycle; watchdog cleared
// S_BUSY      | waiting for frame_done while the frame watchdog runs
module lcd_page_scheduler #(
  parameter int unsigned MIN_HOLD  = 25_000_000,
  parameter int unsigned PAGE_TIME = 100_000_000,
  parameter int unsigned FRAME_TO  = 2_000_000,
  parameter logic [3:0]  CRIT_MASK = 4'b0011
) (
  input logic                  clk,
  input logic                  rst_n,
  lcd_page_scheduler_if.master bus
);

  localparam int unsigned FW = (FRAME_TO < 2) ? 1 : $clog2(FRAME_TO);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TO - 1);

  typedef enum logic [1:0] {
    S_WAIT_INIT,
    S_DECIDE,
    S_ISSUE,
    S_BUSY
  } state_t;

  state_t        state_q;
  logic          frame_start_q;
  logic [1:0]    src_sel_q;
  logic          blank_q;
  logic          switch_q;
  logic          timeout_q;
  logic [31:0]   hold_q;
  logic [FW-1:0] frame_cnt_q;
  logic [FW-1:0] frame_cnt_inc;

  logic [3:0] crit_req;
  logic [3:0] noncrit_req;
  logic       page_hit;
  logic [1:0] page_idx;
  logic [1:0] cand;
  logic [1:0] sel_d;
  logic       blank_d;
  logic       owner_chg;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  assign frame_cnt_inc = frame_cnt_q + FW'(1);

  // Owner decision for the next frame, from the live requests and hold time.
  always_comb begin
    crit_req    = bus.src_req & CRIT_MASK;
    noncrit_req = bus.src_req & ~CRIT_MASK;

    // Next active non-critical source above the owner, wrapping 3 -> 0.
    // Scanning the offsets downwards leaves the nearest one in page_idx.
    page_hit = 1'b0;
    page_idx = src_sel_q;
    cand     = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      cand = src_sel_q + 2'(k);
      if (noncrit_req[cand]) begin
        page_hit = 1'b1;
        page_idx = cand;
      end
    end

    sel_d   = src_sel_q;
    blank_d = blank_q;
    if (blank_q) begin
      if (bus.src_req != 4'd0) begin
        blank_d = 1'b0;
        sel_d   = lowest_idx(bus.src_req);
      end else begin
        sel_d = 2'd0;
      end
    end else if (!bus.src_req[src_sel_q]) begin
      if (crit_req != 4'd0) begin
        sel_d = lowest_idx(crit_req);
      end else if (bus.src_req != 4'd0) begin
        sel_d = lowest_idx(bus.src_req);
      end else begin
        blank_d = 1'b1;
        sel_d   = 2'd0;
      end
    end else if (hold_q >= MIN_HOLD && crit_req != 4'd0 &&
                 (!CRIT_MASK[src_sel_q] || lowest_idx(crit_req) < src_sel_q)) begin
      sel_d = lowest_idx(crit_req);
    end else if (!CRIT_MASK[src_sel_q] && crit_req == 4'd0 &&
                 hold_q >= PAGE_TIME && page_hit) begin
      sel_d = page_idx;
    end

    owner_chg = (blank_d != blank_q) || (sel_d != src_sel_q);
  end

  // Frame sequencing FSM with registered outputs and the hold/watchdog timers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_WAIT_INIT;
      frame_start_q <= 1'b0;
      src_sel_q     <= 2'd0;
      blank_q       <= 1'b1;
      switch_q      <= 1'b0;
      timeout_q     <= 1'b0;
      hold_q        <= '0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= 1'b0;
      switch_q      <= 1'b0;
      if (hold_q != '1) hold_q <= hold_q + 32'd1;

      if (!bus.lcd_ready) begin
        state_q <= S_WAIT_INIT;
      end else begin
        case (state_q)
          S_WAIT_INIT: state_q <= S_DECIDE;
          S_DECIDE: begin
            src_sel_q     <= sel_d;
            blank_q       <= blank_d;
            switch_q      <= owner_chg;
            if (owner_chg) hold_q <= '0;
            frame_start_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
          S_ISSUE: begin
            frame_cnt_q <= '0;
            state_q     <= S_BUSY;
          end
          S_BUSY: begin
            if (bus.frame_done) begin
              state_q <= S_DECIDE;
            end else if (frame_cnt_inc == FRAME_LAST) begin
              // Writer is stuck; drop back and re-arm once it is ready again.
              timeout_q <= 1'b1;
              state_q   <= S_WAIT_INIT;
            end else begin
              frame_cnt_q <= frame_cnt_inc;
            end
          end
          default: state_q <= S_WAIT_INIT;
        endcase
      end
    end
  end

  assign bus.frame_start  = frame_start_q;
  assign bus.src_sel      = src_sel_q;
  assign bus.blank        = blank_q;
  assign bus.switch_pulse = switch_q;
  assign bus.timeout_err  = timeout_q;

endmodule
